// File: rtl/datapath_monitor_pkg.sv
// datapath_monitor_pkg: shared FSM state, dump-kind and halt-cause encodings.
package datapath_monitor_pkg;
  typedef enum logic [2:0] {S_RUN, S_DRAIN_TRACE, S_DUMP_REG, S_DUMP_MEM, S_DONE} state_t;
  typedef enum logic [1:0] {KIND_TRACE = 2'd0, KIND_REG = 2'd1, KIND_MEM = 2'd2} kind_t;
  typedef enum logic [1:0] {CAUSE_NONE = 2'd0, CAUSE_ZERO_INST = 2'd1, CAUSE_TIMEOUT = 2'd2} cause_t;
endpackage

// File: rtl/monitor_trace_buf.sv
// monitor_trace_buf: circular PC trace, read back oldest-first, sticky overflow flag.
module monitor_trace_buf #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        nonempty,
  output logic        rd_last,
  output logic        ovf
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] ram [DEPTH];
  logic [AW-1:0] wr_ptr, rd_cnt;
  logic [AW:0] count;
  always_ff @(posedge clk)
    if (wr_en) ram[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_cnt <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        count <= count == (AW+1)'(DEPTH) ? count : count + (AW+1)'(1);
        ovf <= ovf | (count == (AW+1)'(DEPTH));
      end
      if (rd_en) rd_cnt <= rd_cnt + AW'(1);
    end
  // oldest entry sits count slots behind the write pointer (wraps to wr_ptr when full)
  assign rd_data = ram[wr_ptr - count[AW-1:0] + rd_cnt];
  assign nonempty = count != '0;
  assign rd_last = {1'b0, rd_cnt} == count - (AW+1)'(1);
endmodule

// File: rtl/datapath_run_monitor.sv
// datapath_run_monitor: halts a datapath run, then streams PC trace, registers and a memory window.
// Optional PC trace buffer enabled by RUN_MONITOR_TRACE_EN.
module datapath_run_monitor
  import datapath_monitor_pkg::*;
#(
  parameter int          TRACE_DEPTH    = 16,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter int          NUM_REGS       = 32,
  parameter logic [31:0] MEM_BASE       = 32'h4000,
  parameter int          MEM_WORDS      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] pc_q,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic [1:0]  dump_kind,
  output logic        done,
  output logic [1:0]  halt_cause,
  output logic        trace_ovf
);
  state_t state;
  logic [20:0] cnt;
  logic [31:0] tr_data;
  logic tr_last, has_trace;
  logic accept, zero_hit, to_hit;
  assign accept = dump_valid && dump_ready;
  assign zero_hit = inst_valid && inst == 32'd0;
  assign to_hit = cnt == 21'(TIMEOUT_CYCLES - 1);
`ifdef RUN_MONITOR_TRACE_EN
  logic tr_nonempty;
  monitor_trace_buf #(.DEPTH(TRACE_DEPTH)) u_trace (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (state == S_RUN && inst_valid),
    .wr_data  ({pc_q, 2'b00}),
    .rd_en    (state == S_DRAIN_TRACE && accept),
    .rd_data  (tr_data),
    .nonempty (tr_nonempty),
    .rd_last  (tr_last),
    .ovf      (trace_ovf)
  );
  // the halting cycle's own capture lands on the same edge as the transition
  assign has_trace = tr_nonempty || inst_valid;
`else
  logic unused_cfg;
  assign unused_cfg = ^pc_q ^ (TRACE_DEPTH != 0);
  assign tr_data = '0;
  assign tr_last = 1'b0;
  assign has_trace = 1'b0;
  assign trace_ovf = 1'b0;
`endif
  always_comb
    dump_data = state == S_DUMP_REG ? rf_rdata :
                state == S_DUMP_MEM ? mem_rdata :
                state == S_DRAIN_TRACE ? tr_data : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_RUN;
      cnt <= '0;
      halt_cause <= CAUSE_NONE;
      done <= 1'b0;
      dump_valid <= 1'b0;
      rf_raddr <= '0;
      mem_raddr <= MEM_BASE;
      dump_kind <= KIND_TRACE;
    end else
      case (state)
        S_RUN: begin
          cnt <= cnt + 21'd1;
          if (zero_hit || to_hit) begin
            halt_cause <= zero_hit ? CAUSE_ZERO_INST : CAUSE_TIMEOUT;
            dump_valid <= 1'b1;
            state <= has_trace ? S_DRAIN_TRACE : S_DUMP_REG;
            dump_kind <= has_trace ? KIND_TRACE : KIND_REG;
          end
        end
        S_DRAIN_TRACE:
          if (accept && tr_last) begin
            state <= S_DUMP_REG;
            dump_kind <= KIND_REG;
          end
        S_DUMP_REG:
          if (accept) begin
            if (rf_raddr == 5'(NUM_REGS - 1)) begin
              state <= S_DUMP_MEM;
              dump_kind <= KIND_MEM;
            end else rf_raddr <= rf_raddr + 5'd1;
          end
        S_DUMP_MEM:
          if (accept) begin
            if (mem_raddr == MEM_BASE + 32'(MEM_WORDS - 1)) begin
              state <= S_DONE;
              dump_valid <= 1'b0;
              done <= 1'b1;
            end else mem_raddr <= mem_raddr + 32'd1;
          end
        default: ;
      endcase
endmodule

// File: tb/tb_datapath_run_monitor.sv
// tb_datapath_run_monitor: randomized scoreboard bench; expected beat stream built from run rules.
module tb_datapath_run_monitor;
  logic clk = 1'b0, reset;
  logic [29:0] pc_q;
  logic [31:0] inst, rf_rdata, mem_raddr, mem_rdata, dump_data, moff;
  logic inst_valid, dump_valid, dump_ready, done, trace_ovf;
  logic [4:0] rf_raddr;
  logic [1:0] dump_kind, halt_cause;
  logic [31:0] regs [32];
  logic [31:0] mem_arr [4];
  logic sv [64];
  logic [31:0] si [64];
  logic [29:0] sp [64];
  logic [33:0] exp_q [$];
  logic [33:0] mon_e;
  logic [1:0] exp_cause;
  logic exp_ovf, stall_prev;
  logic [31:0] prev_data;
  logic [1:0] prev_kind;
  int n_checks = 0, n_fail = 0, req_id = 0, ack_id = 0, req_kind = 0, rdy_mode = 0;

  datapath_run_monitor #(.TRACE_DEPTH(16), .TIMEOUT_CYCLES(64), .NUM_REGS(32),
                         .MEM_BASE(32'h4000), .MEM_WORDS(4)) dut (
    .clk(clk), .reset(reset), .pc_q(pc_q), .inst(inst), .inst_valid(inst_valid),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_kind(dump_kind), .done(done), .halt_cause(halt_cause), .trace_ovf(trace_ovf));

  always #5 clk = ~clk;
  assign rf_rdata = regs[rf_raddr];
  assign moff = mem_raddr - 32'h4000;
  assign mem_rdata = moff < 32'd4 ? mem_arr[moff[1:0]] : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard on every accepted beat and services status checks
  always @(negedge clk) begin
    if (req_id != ack_id) begin
      ack_id = req_id;
      if (req_kind == 0) begin
        chk("rst_valid", dump_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_cause", halt_cause, 0);
        chk("rst_ovf", trace_ovf, 0);
        chk("rst_rf_raddr", rf_raddr, 0);
        chk("rst_mem_raddr", mem_raddr, 32'h4000);
        chk("rst_data", dump_data, 0);
        chk("rst_kind", dump_kind, 0);
      end else begin
        chk("end_done", done, 1);
        chk("end_valid", dump_valid, 0);
        chk("end_cause", halt_cause, exp_cause);
        chk("end_ovf", trace_ovf, exp_ovf);
        chk("end_beats_left", exp_q.size(), 0);
      end
    end
    if (!reset) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && dump_valid) begin
        chk("stall_data", dump_data, prev_data);
        chk("stall_kind", dump_kind, prev_kind);
      end
      if (dump_valid && dump_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("beat_kind", dump_kind, mon_e[33:32]);
          chk("beat_data", dump_data, mon_e[31:0]);
        end
      end
      stall_prev = dump_valid && !dump_ready;
      prev_data = dump_data;
      prev_kind = dump_kind;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int k);
    req_kind = k;
    req_id++;
    tick();
  endtask

  task automatic setup(input int kind);
    int pv;
    pv = $urandom_range(0, 4);
    foreach (regs[r]) regs[r] = $urandom;
    foreach (mem_arr[m]) mem_arr[m] = $urandom;
    for (int c = 0; c < 64; c++) begin
      sp[c] = kind <= 3 ? 30'h100000 + 30'(c) : 30'($urandom);
      sv[c] = kind <= 3 ? 1'b1 : kind == 5 ? 1'b0 : $urandom_range(0, 3) < pv;
      si[c] = kind == 5 ? 32'd0 : ($urandom_range(0, 59) == 0 && kind > 5) ? 32'd0 : ($urandom | 32'd1);
    end
    if (kind == 0 || kind == 4) si[3] = 32'd0;
    if (kind == 2) si[63] = 32'd0;
    if (kind == 3) begin
      si[3] = 32'd0;
      regs[2] = 32'h0040_0008;
      regs[3] = 32'h0040_0008;
    end
  endtask

  task automatic run(input bit abort);
    int h;
    logic [31:0] caps [$];
    reset = 1'b0;
    inst_valid = 1'b0;
    tick();
    request(0);
    h = 63;
    for (int c = 0; c < 64; c++)
      if (sv[c] && si[c] == 32'd0) begin
        h = c;
        break;
      end
    exp_cause = (sv[h] && si[h] == 32'd0) ? 2'd1 : 2'd2;
    for (int c = 0; c <= h; c++) if (sv[c]) caps.push_back({sp[c], 2'b00});
    exp_ovf = 1'b0;
`ifdef RUN_MONITOR_TRACE_EN
    exp_ovf = caps.size() > 16;
    for (int k = (caps.size() > 16 ? caps.size() - 16 : 0); k < caps.size(); k++)
      exp_q.push_back({2'd0, caps[k]});
`endif
    for (int r = 0; r < 32; r++) exp_q.push_back({2'd1, regs[r]});
    for (int m = 0; m < 4; m++) exp_q.push_back({2'd2, mem_arr[m]});
    reset = 1'b1;
    for (int c = 0; c < 3000 && !done; c++) begin
      if (c < 64) begin
        inst_valid = sv[c];
        inst = si[c];
        pc_q = sp[c];
      end else begin
        inst_valid = 1'($urandom);
        inst = 32'd0;
        pc_q = 30'($urandom);
      end
      dump_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom) : 1'((c % 4 == 0) || (c % 4 == 3));
      tick();
      if (abort && dump_valid && dump_kind == 2'd1 && rf_raddr == 5'd9) begin
        reset = 1'b0;
        break;
      end
    end
    if (abort) request(0);
    else begin
      request(1);
      repeat (3) tick();
      request(1);
    end
  endtask

  initial begin
    reset = 1'b0;
    inst_valid = 1'b0;
    inst = '0;
    pc_q = '0;
    dump_ready = 1'b0;
    repeat (2) tick();
    setup(0); rdy_mode = 0; run(0);
    setup(1); rdy_mode = 0; run(0);
    setup(2); rdy_mode = 1; run(0);
    setup(3); rdy_mode = 2; run(0);
    setup(4); rdy_mode = 0; run(1);
    setup(5); rdy_mode = 1; run(0);
    for (int i = 0; i < 6; i++) begin
      setup(6);
      rdy_mode = 1;
      run(0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
